// File: rtl/led_cmd_ctrl.sv
// UART command sequencer: parses SYNC/CMD/ARG/CHK frames into LED scanner and RAM writes.
// Optional CMD_ECHO_EN adds an ack_data/ack_valid echo of each frame outcome.
module led_cmd_ctrl #(
  parameter int unsigned          DIV_W        = 24,
  parameter logic [DIV_W-1:0]     SCAN_DIV_RST = 24'h080000,
  parameter int unsigned          RAM_AW       = 8,
  parameter int unsigned          TIMEOUT      = 120000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  output logic [1:0]        led_mode,
  output logic [7:0]        led_pattern,
  output logic [DIV_W-1:0]  scan_div,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              cmd_ok,
  output logic              cmd_err,
  output logic              busy
`ifdef CMD_ECHO_EN
  ,
  output logic [7:0]        ack_data,
  output logic              ack_valid
`endif
);

  localparam int unsigned       TmoW     = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT - 1);
  localparam logic [7:0]        SyncByte = 8'h55;
  localparam logic [7:0]        OpMode   = 8'h01;
  localparam logic [7:0]        OpPat    = 8'h02;
  localparam logic [7:0]        OpDiv    = 8'h03;
  localparam logic [7:0]        OpAddr   = 8'h04;
  localparam logic [7:0]        OpWrite  = 8'h05;

  typedef enum logic [1:0] {SSync, SCmd, SArg, SChk} state_e;

  state_e          state_q;
  logic [7:0]      cmd_q;
  logic [7:0]      arg_q;
  logic [TmoW-1:0] tmo_q;
  logic            chk_match;

  assign chk_match = (rx_data == (cmd_q ^ arg_q ^ SyncByte));
  assign busy      = (state_q != SSync);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SSync;
      cmd_q       <= '0;
      arg_q       <= '0;
      tmo_q       <= '0;
      led_mode    <= 2'd0;
      led_pattern <= 8'h01;
      scan_div    <= SCAN_DIV_RST;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= 8'h00;
      cmd_ok      <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_ok  <= 1'b0;
      cmd_err <= 1'b0;
      ram_we  <= 1'b0;
      // Post-increment so the strobed write lands at the pre-increment address
      if (ram_we) begin
        ram_addr <= ram_addr + RAM_AW'(1);
      end

      unique case (state_q)
        SSync: begin
          tmo_q <= '0;
          if (rx_valid && !rx_error && rx_data == SyncByte) begin
            state_q <= SCmd;
          end
        end
        default: begin
          if (rx_error) begin
            cmd_err <= 1'b1;
            state_q <= SSync;
            tmo_q   <= '0;
          end else if (rx_valid) begin
            tmo_q <= '0;
            case (state_q)
              SCmd: begin
                cmd_q   <= rx_data;
                state_q <= SArg;
              end
              SArg: begin
                arg_q   <= rx_data;
                state_q <= SChk;
              end
              SChk: begin
                state_q <= SSync;
                if (!chk_match) begin
                  cmd_err <= 1'b1;
                end else begin
                  case (cmd_q)
                    OpMode: begin
                      led_mode <= arg_q[1:0];
                      cmd_ok   <= 1'b1;
                    end
                    OpPat: begin
                      if (arg_q == 8'h00) begin
                        cmd_err <= 1'b1;
                      end else begin
                        led_pattern <= arg_q;
                        cmd_ok      <= 1'b1;
                      end
                    end
                    OpDiv: begin
                      if (arg_q == 8'h00) begin
                        cmd_err <= 1'b1;
                      end else begin
                        scan_div <= {arg_q, {(DIV_W - 8){1'b0}}};
                        cmd_ok   <= 1'b1;
                      end
                    end
                    OpAddr: begin
                      ram_addr <= arg_q[RAM_AW-1:0];
                      cmd_ok   <= 1'b1;
                    end
                    OpWrite: begin
                      ram_wdata <= arg_q;
                      ram_we    <= 1'b1;
                      cmd_ok    <= 1'b1;
                    end
                    default: cmd_err <= 1'b1;
                  endcase
                end
              end
              default: state_q <= SSync;
            endcase
          end else if (tmo_q == TmoLast) begin
            cmd_err <= 1'b1;
            state_q <= SSync;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
      endcase
    end
  end

`ifdef CMD_ECHO_EN
  // Echo ACK (06) / NAK (15) one cycle behind the outcome strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_data  <= 8'h00;
      ack_valid <= 1'b0;
    end else begin
      ack_valid <= cmd_ok | cmd_err;
      if (cmd_ok) begin
        ack_data <= 8'h06;
      end else if (cmd_err) begin
        ack_data <= 8'h15;
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Self-checking bench for led_cmd_ctrl: directed frames plus random byte traffic
// compared every cycle against a frame-queue reference model.
module tb_led_cmd_ctrl;

  localparam int unsigned Tmo = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic [1:0]  led_mode;
  logic [7:0]  led_pattern;
  logic [23:0] scan_div;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        cmd_ok;
  logic        cmd_err;
  logic        busy;
`ifdef CMD_ECHO_EN
  logic [7:0]  ack_data;
  logic        ack_valid;
`endif

  led_cmd_ctrl #(
    .DIV_W       (24),
    .SCAN_DIV_RST(24'h080000),
    .RAM_AW      (8),
    .TIMEOUT     (Tmo)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error),
    .led_mode   (led_mode),
    .led_pattern(led_pattern),
    .scan_div   (scan_div),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cmd_ok     (cmd_ok),
    .cmd_err    (cmd_err),
    .busy       (busy)
`ifdef CMD_ECHO_EN
    ,
    .ack_data   (ack_data),
    .ack_valid  (ack_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bytes of the frame in progress, idle cycles, expected outputs
  logic [7:0]  mb[$];
  int          m_idle;
  logic [1:0]  e_mode;
  logic [7:0]  e_pat;
  logic [23:0] e_div;
  logic        e_we;
  logic [7:0]  e_addr;
  logic [7:0]  e_wdata;
  logic        e_ok;
  logic        e_err;
  logic        e_ackv;
  logic [7:0]  e_ackd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb.delete();
    m_idle  = 0;
    e_mode  = 2'd0;
    e_pat   = 8'h01;
    e_div   = 24'h080000;
    e_we    = 1'b0;
    e_addr  = 8'h00;
    e_wdata = 8'h00;
    e_ok    = 1'b0;
    e_err   = 1'b0;
    e_ackv  = 1'b0;
    e_ackd  = 8'h00;
  endtask

  task automatic model_exec();
    logic [7:0] c, a, k;
    c = mb[1];
    a = mb[2];
    k = mb[3];
    mb.delete();
    if (k != (c ^ a ^ 8'h55)) begin
      e_err = 1'b1;
      return;
    end
    case (c)
      8'h01: begin e_mode = a[1:0]; e_ok = 1'b1; end
      8'h02: if (a == 8'h00) e_err = 1'b1; else begin e_pat = a; e_ok = 1'b1; end
      8'h03: if (a == 8'h00) e_err = 1'b1; else begin e_div = {a, 16'h0000}; e_ok = 1'b1; end
      8'h04: begin e_addr = a; e_ok = 1'b1; end
      8'h05: begin e_wdata = a; e_we = 1'b1; e_ok = 1'b1; end
      default: e_err = 1'b1;
    endcase
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge
  task automatic model_step(input logic v, input logic [7:0] d, input logic er);
    logic old_ok, old_err, old_we;
    old_ok  = e_ok;
    old_err = e_err;
    old_we  = e_we;
    e_ok  = 1'b0;
    e_err = 1'b0;
    e_we  = 1'b0;
    if (old_we) e_addr = e_addr + 8'd1;
    e_ackv = old_ok | old_err;
    if (old_ok) e_ackd = 8'h06;
    else if (old_err) e_ackd = 8'h15;
    if (mb.size() == 0) begin
      if (v && !er && d == 8'h55) begin
        mb.push_back(d);
        m_idle = 0;
      end
    end else if (er) begin
      e_err = 1'b1;
      mb.delete();
    end else if (v) begin
      mb.push_back(d);
      m_idle = 0;
      if (mb.size() == 4) model_exec();
    end else begin
      m_idle++;
      if (m_idle == Tmo) begin
        e_err = 1'b1;
        mb.delete();
      end
    end
  endtask

  task automatic compare_all();
    check("led_mode", 32'(led_mode), 32'(e_mode));
    check("led_pattern", 32'(led_pattern), 32'(e_pat));
    check("scan_div", 32'(scan_div), 32'(e_div));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    check("cmd_ok", 32'(cmd_ok), 32'(e_ok));
    check("cmd_err", 32'(cmd_err), 32'(e_err));
    check("busy", 32'(busy), 32'(mb.size() != 0));
`ifdef CMD_ECHO_EN
    check("ack_valid", 32'(ack_valid), 32'(e_ackv));
    check("ack_data", 32'(ack_data), 32'(e_ackd));
`endif
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic er);
    rx_valid = v;
    rx_data  = d;
    rx_error = er;
    @(posedge clk);
    model_step(v, d, er);
    #1;
    compare_all();
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                            input int gap);
    logic [7:0] b[4];
    b[0] = 8'h55;
    b[1] = c;
    b[2] = a;
    b[3] = k;
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      step(1'b1, b[i], 1'b0);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_error = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
    idle(2);

    // Mode command
    send_frame(8'h01, 8'h02, 8'h56, 0);
    check("t1_mode", 32'(led_mode), 32'd2);
    check("t1_ok", 32'(cmd_ok), 32'd1);
    idle(1);
    check("t1_ok_once", 32'(cmd_ok), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // Pattern, then a rejected zero pattern
    send_frame(8'h02, 8'hA5, 8'hF2, 0);
    check("t2_pat", 32'(led_pattern), 32'hA5);
    send_frame(8'h02, 8'h00, 8'h57, 0);
    check("t2_zero_err", 32'(cmd_err), 32'd1);
    check("t2_pat_kept", 32'(led_pattern), 32'hA5);

    // Address wrap across two writes
    send_frame(8'h04, 8'hFF, 8'hAE, 0);
    send_frame(8'h05, 8'h3C, 8'h6C, 0);
    check("t3_we0", 32'(ram_we), 32'd1);
    check("t3_addr0", 32'(ram_addr), 32'hFF);
    send_frame(8'h05, 8'h3C, 8'h6C, 0);
    check("t3_we1", 32'(ram_we), 32'd1);
    check("t3_addr1", 32'(ram_addr), 32'h00);
    check("t3_wdata", 32'(ram_wdata), 32'h3C);
    idle(2);

    // Bad then good checksum for scan_div
    send_frame(8'h03, 8'h10, 8'h47, 0);
    check("t4_bad_err", 32'(cmd_err), 32'd1);
    check("t4_div_kept", 32'(scan_div), 32'h080000);
    send_frame(8'h03, 8'h10, 8'h46, 0);
    check("t4_div", 32'(scan_div), 32'h100000);

    // Timeout after a partial frame, then a good frame
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    idle(Tmo - 1);
    check("t5_busy_before", 32'(busy), 32'd1);
    idle(1);
    check("t5_tmo_err", 32'(cmd_err), 32'd1);
    check("t5_busy_after", 32'(busy), 32'd0);
    send_frame(8'h01, 8'h03, 8'h57, 0);
    check("t5_next_ok", 32'(cmd_ok), 32'd1);
    idle(2);

    // rx_error mid-frame, with a simultaneous byte that must be dropped
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h00, 1'b1);
    check("t6_rxerr", 32'(cmd_err), 32'd1);
    idle(2);

    // Reset while a write frame is in flight
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h05, 1'b0);
    async_reset();
    idle(1);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'h6C, 1'b0);
    check("t7_no_we", 32'(ram_we), 32'd0);
    check("t7_pat_rst", 32'(led_pattern), 32'h01);
    idle(2);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      logic [7:0] c, a, k;
      r = $urandom_range(0, 99);
      c = 8'($urandom_range(0, 6));
      a = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      k = c ^ a ^ 8'h55;
      if (r < 65) begin
        if ($urandom_range(0, 6) == 0) k = k ^ 8'($urandom_range(1, 255));
        send_frame(c, a, k, $urandom_range(0, 1) == 0 ? 0 : 4);
      end else if (r < 75) begin
        step(1'b1, 8'($urandom), 1'b0);
      end else if (r < 83) begin
        step(1'b1, 8'h55, 1'b0);
        if ($urandom_range(0, 1) == 1) step(1'b1, c, 1'b0);
        idle(Tmo + $urandom_range(0, 3) - 2);
      end else if (r < 93) begin
        step(1'b1, 8'h55, 1'b0);
        idle($urandom_range(0, 3));
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      end else if (r < 97) begin
        step(1'($urandom_range(0, 1)), 8'h55, 1'b1);
      end else begin
        step(1'b1, 8'h55, 1'b0);
        async_reset();
      end
      idle($urandom_range(0, 2));
    end

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
